// File: rtl/clk_div_monitor_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_monitor_pkg
// Shared definitions for the clock-divider stages:
//   - mon_state_e : monitor FSM state encoding
//   - LOCK_THRESH : consecutive matching periods required before lock
//   - exp_high()  : expected high width (in reference cycles) for ratio N
//   - exp_low()   : expected low width (in reference cycles) for ratio N
// -----------------------------------------------------------------------------
package clk_div_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } mon_state_e;

  localparam int unsigned LOCK_THRESH = 2;

  // An odd ratio puts the extra cycle in the low phase.
  function automatic int unsigned exp_high(input int unsigned n);
    return n >> 1;
  endfunction

  function automatic int unsigned exp_low(input int unsigned n);
    return n - (n >> 1);
  endfunction

endpackage

// File: rtl/clk_div_monitor_edge.sv
// -----------------------------------------------------------------------------
// clk_edge_det
// Edge detector for a signal that is already synchronous to i_clk.
// Ports:
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_sig         : signal to watch (flop output in the i_clk domain)
//   o_rise_det    : combinational rise detect (i_sig & ~d_q)
//   o_fall_det    : combinational fall detect (~i_sig & d_q)
//   o_rise_pls    : registered rise strobe, one cycle after detection
//   o_fall_pls    : registered fall strobe, one cycle after detection
// -----------------------------------------------------------------------------
module clk_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_rise_det,
  output logic o_fall_det,
  output logic o_rise_pls,
  output logic o_fall_pls
);

  logic d_q;
  logic rise_pls_q;
  logic fall_pls_q;

  assign o_rise_det = i_sig & ~d_q;
  assign o_fall_det = ~i_sig & d_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      d_q        <= 1'b0;
      rise_pls_q <= 1'b0;
      fall_pls_q <= 1'b0;
    end else begin
      d_q        <= i_sig;
      rise_pls_q <= o_rise_det;
      fall_pls_q <= o_fall_det;
    end
  end

  assign o_rise_pls = rise_pls_q;
  assign o_fall_pls = fall_pls_q;

endmodule

// File: rtl/clk_div_monitor.sv
// -----------------------------------------------------------------------------
// clk_div_monitor
// Measures the high/low widths of a divided clock (generated in the same
// reference domain) and checks them against the programmed ratio N.
// Ports:
//   i_ref_clk     : reference clock (rising edge)
//   i_rst         : asynchronous active-high reset
//   i_mon_en      : monitor enable, 0 forces IDLE and clears err/lock
//   i_div_ratio   : programmed divide ratio N (monitoring needs N >= 2)
//   i_div_clk     : divided clock, flop output in the i_ref_clk domain
//   o_rise_pls    : one-cycle strobe, rising edge of i_div_clk seen
//   o_fall_pls    : one-cycle strobe, falling edge of i_div_clk seen
//   o_high_cnt    : last measured high width (ref cycles)
//   o_low_cnt     : last measured low width (ref cycles)
//   o_meas_valid  : one-cycle strobe, a full high+low period was measured
//   o_err         : sticky width-mismatch / stuck-clock flag
//   o_locked      : divided clock matched for LOCK_THRESH periods in a row
// -----------------------------------------------------------------------------
module clk_div_monitor
  import clk_div_monitor_pkg::*;
#(
  parameter int DIV_RATIO_WIDTH = 5
) (
  input  logic                       i_ref_clk,
  input  logic                       i_rst,
  input  logic                       i_mon_en,
  input  logic [DIV_RATIO_WIDTH-1:0] i_div_ratio,
  input  logic                       i_div_clk,
  output logic                       o_rise_pls,
  output logic                       o_fall_pls,
  output logic [DIV_RATIO_WIDTH-1:0] o_high_cnt,
  output logic [DIV_RATIO_WIDTH-1:0] o_low_cnt,
  output logic                       o_meas_valid,
  output logic                       o_err,
  output logic                       o_locked
);

  localparam int W = DIV_RATIO_WIDTH;
  localparam logic [W-1:0] RUN_MAX = {W{1'b1}};
  localparam logic [W-1:0] RUN_ONE = W'(1);

  logic rise_det;
  logic fall_det;

  clk_edge_det u_edge (
    .i_clk      (i_ref_clk),
    .i_rst      (i_rst),
    .i_sig      (i_div_clk),
    .o_rise_det (rise_det),
    .o_fall_det (fall_det),
    .o_rise_pls (o_rise_pls),
    .o_fall_pls (o_fall_pls)
  );

  mon_state_e   state_q, state_d;
  logic [W-1:0] run_q, run_d;
  logic [W-1:0] ratio_q;
  logic [W-1:0] high_cnt_q, high_cnt_d;
  logic [W-1:0] low_cnt_q, low_cnt_d;
  logic         meas_valid_q, meas_valid_d;
  logic         err_q, err_d;
  logic         locked_q, locked_d;
  logic [1:0]   good_q, good_d;
  // Remembers whether the high phase of the current period matched, so the
  // period is only counted as good when both halves were right.
  logic         high_ok_q, high_ok_d;

  logic [W-1:0] exp_high_w;
  logic [W-1:0] exp_low_w;
  logic [W-1:0] run_inc;
  logic [1:0]   good_inc;
  logic         ratio_chg;
  logic         ratio_ok;

  assign exp_high_w = W'(exp_high(32'(ratio_q)));
  assign exp_low_w  = W'(exp_low(32'(ratio_q)));
  assign run_inc    = (run_q == RUN_MAX) ? RUN_MAX : run_q + RUN_ONE;
  assign good_inc   = (good_q == 2'd3) ? 2'd3 : good_q + 2'd1;
  assign ratio_chg  = (i_div_ratio != ratio_q);
  assign ratio_ok   = (i_div_ratio > W'(1));

  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    high_cnt_d   = high_cnt_q;
    low_cnt_d    = low_cnt_q;
    meas_valid_d = 1'b0;
    err_d        = err_q;
    locked_d     = locked_q;
    good_d       = good_q;
    high_ok_d    = high_ok_q;

    if (!i_mon_en) begin
      state_d   = IDLE;
      run_d     = '0;
      err_d     = 1'b0;
      locked_d  = 1'b0;
      good_d    = 2'd0;
      high_ok_d = 1'b0;
    end else if (state_q != IDLE && ratio_chg) begin
      // Ratio change wins over any edge seen in the same cycle; the
      // measurement restarts without flagging an error.
      state_d   = WAIT_RISE;
      run_d     = '0;
      locked_d  = 1'b0;
      good_d    = 2'd0;
      high_ok_d = 1'b0;
    end else if (!ratio_ok) begin
      // Bypass ratios (0/1) cannot be measured.
      state_d   = IDLE;
      run_d     = '0;
      err_d     = 1'b0;
      locked_d  = 1'b0;
      good_d    = 2'd0;
      high_ok_d = 1'b0;
    end else if (state_q != IDLE && run_q == RUN_MAX) begin
      // Stuck clock: no edge for the full counter range.
      state_d   = WAIT_RISE;
      run_d     = '0;
      err_d     = 1'b1;
      locked_d  = 1'b0;
      good_d    = 2'd0;
      high_ok_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = WAIT_RISE;
          run_d   = '0;
        end
        WAIT_RISE: begin
          if (rise_det) begin
            state_d = MEAS_HIGH;
            run_d   = RUN_ONE;
          end else if (!fall_det) begin
            run_d = run_inc;
          end
        end
        MEAS_HIGH: begin
          if (fall_det) begin
            state_d    = MEAS_LOW;
            high_cnt_d = run_q;
            run_d      = RUN_ONE;
            if (run_q == exp_high_w) begin
              high_ok_d = 1'b1;
            end else begin
              high_ok_d = 1'b0;
              err_d     = 1'b1;
              locked_d  = 1'b0;
              good_d    = 2'd0;
            end
          end else if (!rise_det) begin
            run_d = run_inc;
          end
        end
        MEAS_LOW: begin
          if (rise_det) begin
            state_d      = MEAS_HIGH;
            low_cnt_d    = run_q;
            run_d        = RUN_ONE;
            meas_valid_d = 1'b1;
            high_ok_d    = 1'b0;
            if (run_q != exp_low_w) begin
              err_d    = 1'b1;
              locked_d = 1'b0;
              good_d   = 2'd0;
            end else if (high_ok_q) begin
              good_d = good_inc;
              if (32'(good_inc) >= LOCK_THRESH) begin
                locked_d = 1'b1;
              end
            end
          end else if (!fall_det) begin
            run_d = run_inc;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      run_q        <= '0;
      ratio_q      <= '0;
      high_cnt_q   <= '0;
      low_cnt_q    <= '0;
      meas_valid_q <= 1'b0;
      err_q        <= 1'b0;
      locked_q     <= 1'b0;
      good_q       <= 2'd0;
      high_ok_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      ratio_q      <= i_div_ratio;
      high_cnt_q   <= high_cnt_d;
      low_cnt_q    <= low_cnt_d;
      meas_valid_q <= meas_valid_d;
      err_q        <= err_d;
      locked_q     <= locked_d;
      good_q       <= good_d;
      high_ok_q    <= high_ok_d;
    end
  end

  assign o_high_cnt   = high_cnt_q;
  assign o_low_cnt    = low_cnt_q;
  assign o_meas_valid = meas_valid_q;
  assign o_err        = err_q;
  assign o_locked     = locked_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
module tb_clk_div_monitor;
  import clk_div_monitor_pkg::*;

  logic       clk;
  logic       i_rst;
  logic       i_mon_en;
  logic [4:0] i_div_ratio;
  logic       i_div_clk;
  logic       o_rise_pls;
  logic       o_fall_pls;
  logic [4:0] o_high_cnt;
  logic [4:0] o_low_cnt;
  logic       o_meas_valid;
  logic       o_err;
  logic       o_locked;

  int tests;
  int fails;

  clk_div_monitor #(.DIV_RATIO_WIDTH(5)) dut (
    .i_ref_clk    (clk),
    .i_rst        (i_rst),
    .i_mon_en     (i_mon_en),
    .i_div_ratio  (i_div_ratio),
    .i_div_clk    (i_div_clk),
    .o_rise_pls   (o_rise_pls),
    .o_fall_pls   (o_fall_pls),
    .o_high_cnt   (o_high_cnt),
    .o_low_cnt    (o_low_cnt),
    .o_meas_valid (o_meas_valid),
    .o_err        (o_err),
    .o_locked     (o_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the divided clock for one reference edge, then settle past it.
  task automatic step(input logic v);
    i_div_clk = v;
    @(posedge clk);
    #1;
  endtask

  task automatic half(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  // Disable, program ratio, re-enable; ends in WAIT_RISE with div clk low.
  task automatic start(input logic [4:0] n);
    i_mon_en = 1'b0;
    i_div_ratio = n;
    half(1'b0, 2);
    i_mon_en = 1'b1;
    half(1'b0, 2);
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_mon_en = 1'b0; i_div_ratio = 5'd0; i_div_clk = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    tests++; if ({o_rise_pls, o_fall_pls, o_meas_valid, o_err, o_locked} !== 5'b0) begin fails++; $display("FAIL reset_flags: got %b expected 00000", {o_rise_pls, o_fall_pls, o_meas_valid, o_err, o_locked}); end
    tests++; if ({o_high_cnt, o_low_cnt} !== 10'd0) begin fails++; $display("FAIL reset_cnts: got %0d/%0d expected 0/0", o_high_cnt, o_low_cnt); end
    tests++; if (dut.state_q !== IDLE) begin fails++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE); end
    i_rst = 1'b0;
    $display("[TB] test_reset done");
  endtask

  task automatic test_n4;
    start(5'd4);
    half(1'b1, 1);
    tests++; if (o_rise_pls !== 1'b1) begin fails++; $display("FAIL n4_rise_pls: got %b expected 1", o_rise_pls); end
    half(1'b1, 1);
    half(1'b0, 1);
    tests++; if (o_fall_pls !== 1'b1) begin fails++; $display("FAIL n4_fall_pls: got %b expected 1", o_fall_pls); end
    tests++; if (o_high_cnt !== 5'd2) begin fails++; $display("FAIL n4_high: got %0d expected 2", o_high_cnt); end
    half(1'b0, 1);
    half(1'b1, 1);
    tests++; if (o_meas_valid !== 1'b1) begin fails++; $display("FAIL n4_valid1: got %b expected 1", o_meas_valid); end
    tests++; if (o_low_cnt !== 5'd2) begin fails++; $display("FAIL n4_low: got %0d expected 2", o_low_cnt); end
    tests++; if (o_locked !== 1'b0) begin fails++; $display("FAIL n4_lock_early: got %b expected 0", o_locked); end
    half(1'b1, 1);
    tests++; if (o_meas_valid !== 1'b0) begin fails++; $display("FAIL n4_valid_pulse: got %b expected 0", o_meas_valid); end
    half(1'b0, 2);
    half(1'b1, 1);
    tests++; if (o_meas_valid !== 1'b1 || o_locked !== 1'b1) begin fails++; $display("FAIL n4_lock: got valid=%b locked=%b expected 1/1", o_meas_valid, o_locked); end
    tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL n4_err: got %b expected 0", o_err); end
    $display("[TB] test_n4 done");
  endtask

  task automatic test_n5;
    start(5'd5);
    half(1'b1, 2); half(1'b0, 3); half(1'b1, 1);
    tests++; if (o_meas_valid !== 1'b1 || o_high_cnt !== 5'd2 || o_low_cnt !== 5'd3) begin fails++; $display("FAIL n5_widths: got valid=%b %0d/%0d expected 1 2/3", o_meas_valid, o_high_cnt, o_low_cnt); end
    half(1'b1, 1); half(1'b0, 3); half(1'b1, 1);
    tests++; if (o_locked !== 1'b1 || o_err !== 1'b0) begin fails++; $display("FAIL n5_lock: got locked=%b err=%b expected 1/0", o_locked, o_err); end
    $display("[TB] test_n5 done");
  endtask

  task automatic test_n6_stretch;
    start(5'd6);
    half(1'b1, 3); half(1'b0, 3); half(1'b1, 3); half(1'b0, 3); half(1'b1, 1);
    tests++; if (o_locked !== 1'b1) begin fails++; $display("FAIL n6_lock: got %b expected 1", o_locked); end
    half(1'b1, 3);
    half(1'b0, 1);
    tests++; if (o_high_cnt !== 5'd4 || o_err !== 1'b1 || o_locked !== 1'b0) begin fails++; $display("FAIL n6_stretch: got high=%0d err=%b locked=%b expected 4/1/0", o_high_cnt, o_err, o_locked); end
    half(1'b0, 2); half(1'b1, 3); half(1'b0, 3); half(1'b1, 1);
    tests++; if (o_err !== 1'b1 || o_locked !== 1'b0) begin fails++; $display("FAIL n6_sticky: got err=%b locked=%b expected 1/0", o_err, o_locked); end
    i_mon_en = 1'b0;
    half(1'b0, 1);
    tests++; if (o_err !== 1'b0 || o_locked !== 1'b0 || o_high_cnt !== 5'd3) begin fails++; $display("FAIL n6_disable: got err=%b locked=%b high=%0d expected 0/0/3", o_err, o_locked, o_high_cnt); end
    $display("[TB] test_n6_stretch done");
  endtask

  task automatic test_stuck;
    start(5'd8);
    half(1'b1, 31);
    tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL stuck_early: got %b expected 0", o_err); end
    half(1'b0, 1);
    tests++; if (o_err !== 1'b1 || o_locked !== 1'b0) begin fails++; $display("FAIL stuck_err: got err=%b locked=%b expected 1/0", o_err, o_locked); end
    tests++; if (dut.state_q !== WAIT_RISE) begin fails++; $display("FAIL stuck_state: got %0d expected %0d", dut.state_q, WAIT_RISE); end
    $display("[TB] test_stuck done");
  endtask

  task automatic test_ratio_change;
    start(5'd4);
    half(1'b1, 2); half(1'b0, 2); half(1'b1, 2); half(1'b0, 2); half(1'b1, 1);
    tests++; if (o_locked !== 1'b1) begin fails++; $display("FAIL chg_prelock: got %b expected 1", o_locked); end
    i_div_ratio = 5'd6;
    half(1'b1, 1);
    tests++; if (o_locked !== 1'b0 || o_err !== 1'b0 || dut.state_q !== WAIT_RISE) begin fails++; $display("FAIL chg_unlock: got locked=%b err=%b state=%0d expected 0/0/%0d", o_locked, o_err, dut.state_q, WAIT_RISE); end
    half(1'b0, 3); half(1'b1, 3); half(1'b0, 3); half(1'b1, 1);
    tests++; if (o_meas_valid !== 1'b1 || o_locked !== 1'b0 || o_high_cnt !== 5'd3 || o_low_cnt !== 5'd3) begin fails++; $display("FAIL chg_first: got valid=%b locked=%b %0d/%0d expected 1/0 3/3", o_meas_valid, o_locked, o_high_cnt, o_low_cnt); end
    half(1'b1, 2); half(1'b0, 3); half(1'b1, 1);
    tests++; if (o_locked !== 1'b1 || o_err !== 1'b0) begin fails++; $display("FAIL chg_relock: got locked=%b err=%b expected 1/0", o_locked, o_err); end
    $display("[TB] test_ratio_change done");
  endtask

  task automatic test_bypass;
    i_mon_en = 1'b1;
    i_div_ratio = 5'd1;
    half(1'b0, 2);
    half(1'b1, 1);
    tests++; if (o_rise_pls !== 1'b1 || dut.state_q !== IDLE) begin fails++; $display("FAIL byp1_rise: got rise=%b state=%0d expected 1/%0d", o_rise_pls, dut.state_q, IDLE); end
    half(1'b1, 1);
    half(1'b0, 1);
    tests++; if (o_fall_pls !== 1'b1 || o_meas_valid !== 1'b0 || o_err !== 1'b0 || o_locked !== 1'b0) begin fails++; $display("FAIL byp1_flags: got fall=%b valid=%b err=%b locked=%b expected 1/0/0/0", o_fall_pls, o_meas_valid, o_err, o_locked); end
    i_div_ratio = 5'd0;
    half(1'b1, 1);
    tests++; if (o_rise_pls !== 1'b1 || dut.state_q !== IDLE) begin fails++; $display("FAIL byp0: got rise=%b state=%0d expected 1/%0d", o_rise_pls, dut.state_q, IDLE); end
    $display("[TB] test_bypass done");
  endtask

  task automatic test_reset_mid;
    start(5'd4);
    half(1'b1, 2);
    half(1'b0, 1);
    #2 i_rst = 1'b1;
    #1;
    tests++; if ({o_rise_pls, o_fall_pls, o_meas_valid, o_err, o_locked} !== 5'b0 || {o_high_cnt, o_low_cnt} !== 10'd0) begin fails++; $display("FAIL rstmid_outputs: got flags=%b %0d/%0d expected 00000 0/0", {o_rise_pls, o_fall_pls, o_meas_valid, o_err, o_locked}, o_high_cnt, o_low_cnt); end
    @(posedge clk); #1;
    i_rst = 1'b0;
    half(1'b0, 2);
    half(1'b1, 1);
    tests++; if (o_meas_valid !== 1'b0 || dut.state_q !== MEAS_HIGH) begin fails++; $display("FAIL rstmid_fresh: got valid=%b state=%0d expected 0/%0d", o_meas_valid, dut.state_q, MEAS_HIGH); end
    half(1'b1, 1); half(1'b0, 2); half(1'b1, 1);
    tests++; if (o_meas_valid !== 1'b1 || o_high_cnt !== 5'd2 || o_low_cnt !== 5'd2) begin fails++; $display("FAIL rstmid_meas: got valid=%b %0d/%0d expected 1 2/2", o_meas_valid, o_high_cnt, o_low_cnt); end
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset;
    test_n4;
    test_n5;
    test_n6_stretch;
    test_stuck;
    test_ratio_change;
    test_bypass;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
